// File: rtl/eaglesong_absorb_stream_pkg.sv
// Shared types and helpers for the Eaglesong absorb stream.
// Covers the state word array, the absorb FSM encoding and the byte-to-state mapping.
package eaglesong_pkg;

  localparam int          RATE_WORDS_DEFAULT  = 8;
  localparam int          STATE_WORDS_DEFAULT = 16;
  localparam logic [7:0]  DELIM_DEFAULT       = 8'h06;

  typedef logic [STATE_WORDS_DEFAULT-1:0][31:0] state_t;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    PERM_WAIT = 2'd1,
    PAD       = 2'd2,
    DONE      = 2'd3
  } absorb_fsm_e;

  typedef struct packed {
    logic [15:0] word;
    logic [15:0] lsb;
  } byte_lane_t;

  // Byte p lands big-endian inside word p/4: byte 0 of a word is its top byte.
  function automatic byte_lane_t byte_lane(input int p);
    byte_lane_t l;
    l.word = 16'(p / 4);
    l.lsb  = 16'(24 - 8 * (p % 4));
    return l;
  endfunction

endpackage

// File: rtl/eaglesong_absorb_stream_if.sv
// Message byte stream into the absorb engine (valid/ready with last and byte count).
interface eaglesong_absorb_stream_if #(
  parameter int IN_BYTES = 4
) ();
  logic                          in_valid;
  logic                          in_ready;
  logic [8*IN_BYTES-1:0]         in_data;
  logic                          in_last;
  logic [$clog2(IN_BYTES+1)-1:0] in_nbytes;

  modport master (output in_valid, in_data, in_last, in_nbytes, input in_ready);
  modport slave  (input in_valid, in_data, in_last, in_nbytes, output in_ready);
endinterface

// File: rtl/eaglesong_absorb_stream_rate_inject.sv
// Combinational XOR of one beat of message bytes (plus optional delimiter) into the rate words.
module eaglesong_rate_inject
  import eaglesong_pkg::*;
#(
  parameter int         RATE_WORDS = RATE_WORDS_DEFAULT,
  parameter int         IN_BYTES   = 4,
  parameter int         CW         = 6,
  parameter int         NBW        = 3,
  parameter logic [7:0] DELIM      = DELIM_DEFAULT
) (
  input  logic [RATE_WORDS-1:0][31:0] rate_i,
  input  logic [CW-1:0]               cnt,
  input  logic [8*IN_BYTES-1:0]       data,
  input  logic [NBW-1:0]              nbytes,
  input  logic                        dlm_en,
  output logic [RATE_WORDS-1:0][31:0] rate_o
);
  localparam int RATE_BYTES = 4 * RATE_WORDS;

  logic [32*RATE_WORDS-1:0] mask;
  logic [CW-1:0]            dlm_pos;

  assign dlm_pos = cnt + CW'(nbytes);

  // Each rate byte position picks whichever beat byte (if any) maps onto it.
  for (genvar p = 0; p < RATE_BYTES; p++) begin : g_lane
    localparam byte_lane_t LN  = byte_lane(p);
    localparam int         OFS = 32 * int'(LN.word) + int'(LN.lsb);
    logic [7:0] x;

    always_comb begin
      x = '0;
      for (int k = 0; k < IN_BYTES; k++)
        if (NBW'(k) < nbytes && cnt + CW'(k) == CW'(p)) x = x ^ data[8*k +: 8];
      if (dlm_en && dlm_pos == CW'(p)) x = x ^ DELIM;
    end

    assign mask[OFS +: 8] = x;
  end

  assign rate_o = rate_i ^ mask;

endmodule

// File: rtl/eaglesong_absorb_stream.sv
// Eaglesong absorb engine: streams message bytes into the rate, pads with the delimiter,
// and drives an external permutation core once per completed block.
module eaglesong_absorb_stream
  import eaglesong_pkg::*;
#(
  parameter int         IN_BYTES    = 4,
  parameter int         RATE_WORDS  = RATE_WORDS_DEFAULT,
  parameter int         STATE_WORDS = STATE_WORDS_DEFAULT,
  parameter logic [7:0] DELIM       = DELIM_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  eaglesong_absorb_stream_if.slave     in_s,
  output logic                         perm_start,
  output logic [STATE_WORDS-1:0][31:0] perm_state_o,
  input  logic                         perm_done,
  input  logic [STATE_WORDS-1:0][31:0] perm_state_i,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [STATE_WORDS-1:0][31:0] state_o
);
  localparam int RATE_BYTES = 4 * RATE_WORDS;
  localparam int CW         = $clog2(RATE_BYTES) + 1;
  localparam int NBW        = $clog2(IN_BYTES + 1);

  absorb_fsm_e                  fsm;
  logic [STATE_WORDS-1:0][31:0] st;
  logic [RATE_WORDS-1:0][31:0]  rate_new;
  logic [CW-1:0]                cnt, end_pos, inj_cnt;
  logic [NBW-1:0]               inj_nb;
  logic                         inj_dlm, final_q, pad_pending, in_ready_q;
  logic                         accept, blk_full;

  assign end_pos  = cnt + CW'(in_s.in_nbytes);
  assign blk_full = (end_pos == CW'(RATE_BYTES));
  assign accept   = in_s.in_valid && in_s.in_ready;

  // PAD reuses the injector as a zero-byte beat with the delimiter at position 0.
  always_comb begin
    inj_cnt = cnt;
    inj_nb  = in_s.in_nbytes;
    inj_dlm = in_s.in_last && !blk_full;
    if (fsm == PAD) begin
      inj_cnt = '0;
      inj_nb  = '0;
      inj_dlm = 1'b1;
    end
  end

  eaglesong_rate_inject #(
    .RATE_WORDS(RATE_WORDS),
    .IN_BYTES  (IN_BYTES),
    .CW        (CW),
    .NBW       (NBW),
    .DELIM     (DELIM)
  ) u_inject (
    .rate_i(st[RATE_WORDS-1:0]),
    .cnt   (inj_cnt),
    .data  (in_s.in_data),
    .nbytes(inj_nb),
    .dlm_en(inj_dlm),
    .rate_o(rate_new)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= FILL;
      st          <= '0;
      cnt         <= '0;
      final_q     <= 1'b0;
      pad_pending <= 1'b0;
      perm_start  <= 1'b0;
      out_valid   <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      perm_start <= 1'b0;
      case (fsm)
        FILL: begin
          if (accept) begin
            st[RATE_WORDS-1:0] <= rate_new;
            if (in_s.in_last || blk_full) begin
              cnt         <= '0;
              perm_start  <= 1'b1;
              in_ready_q  <= 1'b0;
              final_q     <= in_s.in_last && !blk_full;
              pad_pending <= in_s.in_last && blk_full;
              fsm         <= PERM_WAIT;
            end else begin
              cnt <= end_pos;
            end
          end
        end
        PERM_WAIT: begin
          if (perm_done) begin
            st <= perm_state_i;
            if (final_q) begin
              out_valid <= 1'b1;
              fsm       <= DONE;
            end else if (pad_pending) begin
              pad_pending <= 1'b0;
              fsm         <= PAD;
            end else begin
              in_ready_q <= 1'b1;
              fsm        <= FILL;
            end
          end
        end
        PAD: begin
          st[RATE_WORDS-1:0] <= rate_new;
          perm_start         <= 1'b1;
          final_q            <= 1'b1;
          fsm                <= PERM_WAIT;
        end
        DONE: begin
          if (out_ready) begin
            st         <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            in_ready_q <= 1'b1;
            fsm        <= FILL;
          end
        end
        default: fsm <= FILL;
      endcase
    end
  end

  // in_ready is forced low while reset is held so the reset cycle never accepts.
  assign in_s.in_ready = in_ready_q && !rst;
  assign perm_state_o  = st;
  assign state_o       = st;

endmodule
